// File: rtl/dl_pkg.sv
// Shared constants, FSM encoding and RAM address layout for the delay-line voice scheduler.
package dl_pkg;

    localparam int unsigned VOICES   = 8;
    localparam int unsigned SEG_BITS = 8;
    localparam int unsigned DW       = 18;
    localparam int unsigned VW       = $clog2(VOICES);
    localparam int unsigned AW       = VW + SEG_BITS;

    // Length 0 encodes a full 2^SEG_BITS-sample delay.
    localparam logic [SEG_BITS-1:0] LEN_RST = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WIN  = 2'd2,
        WR   = 2'd3
    } state_t;

    typedef struct packed {
        logic [VW-1:0]       voice;
        logic [SEG_BITS-1:0] ptr;
    } ram_addr_t;

endpackage

// File: rtl/dl_ptr_bank.sv
// Per-voice write pointers and delay lengths, plus read/write address generation.
module dl_ptr_bank
    import dl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                len_we,
    input  logic [VW-1:0]       len_voice,
    input  logic [SEG_BITS-1:0] len_val,
    input  logic                wp_inc,
    input  logic [VW-1:0]       wr_voice,
    input  logic [VW-1:0]       rd_voice,
    output ram_addr_t           rd_addr_c,
    output ram_addr_t           wr_addr_c
);

    logic [SEG_BITS-1:0] wp  [VOICES];
    logic [SEG_BITS-1:0] len [VOICES];
    logic [SEG_BITS-1:0] rd_len_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                wp[i]  <= '0;
                len[i] <= LEN_RST;
            end
        end else begin
            if (len_we) begin
                len[len_voice] <= len_val;
            end
            if (wp_inc) begin
                wp[wr_voice] <= wp[wr_voice] + 1'b1;
            end
        end
    end

    // The read address is registered one cycle ahead of RD, so a length written in that cycle is forwarded.
    always_comb begin
        rd_len_c        = (len_we && (len_voice == rd_voice)) ? len_val : len[rd_voice];
        rd_addr_c.voice = rd_voice;
        rd_addr_c.ptr   = wp[rd_voice] - rd_len_c;
        wr_addr_c.voice = wr_voice;
        wr_addr_c.ptr   = wp[wr_voice];
    end

endmodule

// File: rtl/dl_voice_sched.sv
// Frame scheduler sharing one delay-line RAM between all voices: read tap, wait for new sample, write back.
module dl_voice_sched
    import dl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                len_we,
    input  logic [VW-1:0]       len_voice,
    input  logic [SEG_BITS-1:0] len_val,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_din,
    output logic                ram_we,
    input  logic [DW-1:0]       ram_dout,
    output logic [DW-1:0]       out_data,
    output logic                out_valid,
    output logic [VW-1:0]       out_voice,
    output logic                in_req,
    input  logic [DW-1:0]       in_data,
    input  logic                in_valid,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    state_t        state, state_nxt;
    logic [VW-1:0] voice, voice_nxt;
    logic [VW-1:0] rd_voice_c;
    ram_addr_t     rd_addr_c, wr_addr_c;
    logic          wp_inc_c;

    logic [AW-1:0] ram_addr_nxt;
    logic [DW-1:0] ram_din_nxt, out_data_nxt;
    logic [VW-1:0] out_voice_nxt;
    logic          ram_we_nxt, out_valid_nxt, in_req_nxt, busy_nxt, frame_done_nxt, overrun_nxt;

    // Voice whose tap is read next: voice 0 from IDLE, otherwise the successor of the voice being written.
    assign rd_voice_c = (state == WR) ? VW'(voice + 1'b1) : '0;
    assign wp_inc_c   = (state == WR);

    dl_ptr_bank u_ptr_bank (
        .clk       (clk),
        .reset     (reset),
        .len_we    (len_we),
        .len_voice (len_voice),
        .len_val   (len_val),
        .wp_inc    (wp_inc_c),
        .wr_voice  (voice),
        .rd_voice  (rd_voice_c),
        .rd_addr_c (rd_addr_c),
        .wr_addr_c (wr_addr_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            voice      <= '0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_we     <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_voice  <= '0;
            in_req     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            voice      <= voice_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_din    <= ram_din_nxt;
            ram_we     <= ram_we_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            out_voice  <= out_voice_nxt;
            in_req     <= in_req_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // Next-state and next-output logic; outputs are registered so each value is set on entry to its state.
    always_comb begin
        state_nxt      = state;
        voice_nxt      = voice;
        ram_addr_nxt   = ram_addr;
        ram_din_nxt    = ram_din;
        ram_we_nxt     = 1'b0;
        out_data_nxt   = out_data;
        out_valid_nxt  = 1'b0;
        out_voice_nxt  = out_voice;
        in_req_nxt     = in_req;
        frame_done_nxt = 1'b0;
        overrun_nxt    = overrun | (sample_tick && (state != IDLE));

        case (state)
            IDLE: begin
                if (sample_tick) begin
                    state_nxt     = RD;
                    voice_nxt     = rd_voice_c;
                    out_voice_nxt = rd_voice_c;
                    ram_addr_nxt  = rd_addr_c;
                end
            end
            RD: begin
                state_nxt     = WIN;
                out_data_nxt  = ram_dout;
                out_valid_nxt = 1'b1;
                in_req_nxt    = 1'b1;
            end
            WIN: begin
                if (in_valid) begin
                    state_nxt    = WR;
                    ram_din_nxt  = in_data;
                    ram_addr_nxt = wr_addr_c;
                    ram_we_nxt   = 1'b1;
                    in_req_nxt   = 1'b0;
                end
            end
            WR: begin
                if (voice == VW'(VOICES - 1)) begin
                    state_nxt      = IDLE;
                    frame_done_nxt = 1'b1;
                end else begin
                    state_nxt     = RD;
                    voice_nxt     = rd_voice_c;
                    out_voice_nxt = rd_voice_c;
                    ram_addr_nxt  = rd_addr_c;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: doc/dl_voice_sched.md
Name: dl_voice_sched

Overview:
- Time-multiplexed scheduler that shares one 2048x18 delay-line RAM between 8 waveguide voices.
- The RAM has an asynchronous read and a synchronous write; it is split into one 256-entry circular segment per voice.
- On each audio sample tick the block visits every voice in order:
  - reads that voice's delay tap and hands the sample to the voice datapath (filter/excitation);
  - accepts the new sample back and writes it at that voice's write pointer.
- Per-voice delay length (pitch) is set through a simple register-write port.

Parameters:
VOICES, 8, number of voices; must be a power of two
SEG_BITS, 8, log2 of segment depth per voice (256 entries)
DW, 18, sample width
AW, 11, RAM address width; equals log2(VOICES)+SEG_BITS
LEN_RST, 8'd0, delay length loaded into every voice at reset (0 encodes 256)

Ports:
clk  in  1  system clock, all logic on its rising edge
reset  in  1  asynchronous active-high reset
sample_tick  in  1  single-cycle pulse that starts one frame (one pass over all voices)
len_we  in  1  delay-length register write strobe
len_voice  in  3  voice index for len_we
len_val  in  SEG_BITS  delay length in samples; 0 means 2^SEG_BITS
ram_addr  out  AW  address to the delay RAM, formed as {voice, pointer}
ram_din  out  DW  write data to the delay RAM
ram_we  out  1  write enable to the delay RAM
ram_dout  in  DW  asynchronous read data from the delay RAM
out_data  out  DW  delay-tap sample for out_voice
out_valid  out  1  one-cycle pulse; out_data/out_voice are valid
out_voice  out  3  voice currently being serviced
in_req  out  1  block is waiting for this voice's new sample
in_data  in  DW  new sample from the voice datapath
in_valid  in  1  in_data is valid; sampled only while in_req=1
busy  out  1  a frame is in progress
frame_done  out  1  one-cycle pulse when the last voice has been written
overrun  out  1  sticky flag: sample_tick arrived while busy; cleared only by reset

Behaviour:
- Reset (asynchronous):
  - state=IDLE; all write pointers wp[v]=0; all len[v]=LEN_RST; voice counter=0.
  - All outputs are 0, including ram_we=0 and overrun=0.
  - RAM contents are not cleared.
- State machine: IDLE, RD, WIN, WR.
  - IDLE: on sample_tick go to RD with voice=0. busy=0.
  - RD (exactly 1 cycle):
    - ram_addr={voice, wp[voice]-len[voice]}, with the subtraction taken mod 2^SEG_BITS;
    - ram_dout is registered into out_data; next state is WIN.
  - WIN:
    - out_valid=1 for the first cycle only; in_req=1 throughout.
    - When in_valid=1, register in_data into ram_din and go to WR. The block waits indefinitely otherwise.
  - WR (1 cycle):
    - ram_addr={voice, wp[voice]}, ram_we=1;
    - wp[voice] increments with wrap at 2^SEG_BITS.
    - If voice=VOICES-1, go to IDLE and pulse frame_done in the same cycle the block enters IDLE. Otherwise voice+1 and go to RD.
- Latency:
  - sample_tick at cycle 0 → RD at cycle 1 → out_valid at cycle 2.
  - With in_valid driven in cycle 2, WR occurs at cycle 3.
  - Minimum 3 cycles per voice, so 24+1 cycles per frame.
- Delay semantics: the tap returns the sample written len frames earlier. len=0 reads wp before it is overwritten, giving a delay of 256.
- out_voice holds the current voice in RD/WIN/WR and holds its last value in IDLE.
- ram_addr/ram_din hold their last values when ram_we=0.
- len_we:
  - The write takes effect at the next RD of that voice.
  - If the write lands in the same cycle as that voice's RD, the old length is used this frame.
  - len_we is accepted in any state.
- sample_tick while busy: the tick is ignored, overrun is set, and the frame continues unchanged.
- in_valid while in_req=0: ignored.
- Reset mid-frame: the block returns immediately to IDLE. Pointers are reset and any partial write is abandoned; ram_we drops asynchronously.

Decomposition:
- Shared package (dl_pkg) holds:
  - constants VOICES, SEG_BITS, DW, AW;
  - the state encoding (IDLE=0, RD=1, WIN=2, WR=3);
  - the voice-index width.
- Optional sub-module dl_ptr_bank holds wp[] and len[] with a write port and a read mux, and computes the read and write addresses.
- The FSM stays in dl_voice_sched. The RAM itself is external.

Test Plan:
- Reset then idle → busy=0, out_valid=0, ram_we=0, overrun=0. One tick with in_valid tied high → exactly 8 out_valid pulses for voices 0..7, frame_done at cycle 25, ram_we addresses 0x000, 0x100, ..., 0x700.
- Voice 2 len=3; return values 1,2,3,... on successive frames → voice-2 out_data at frames 4,5,6 = 1,2,3 (earlier frames return prior RAM contents). Voice 2 read addresses wrap correctly after 256 frames (0x2FF → 0x200).
- len=0 on voice 5; write k at frame k → out_data at frame 256 is 0, at frame 257 is 1 (delay of 256).
- Hold in_valid low for 10 cycles in WIN of voice 4 → in_req stays high, no ram_we, no state advance. A sample_tick during the stall sets overrun=1 and the frame length is unchanged.
- len_we for voice 1 in the same cycle as voice 1's RD → old length used this frame, new length used next frame.
- Assert reset during WR of voice 6 → ram_we=0 immediately, state IDLE, wp all 0. The next tick starts at voice 0 at address {0,0}.
